// File: rtl/lcd_nibble_receiver.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// lcd_nibble_receiver
//
// Purpose:
//   Passive monitor for a 4-bit HD44780-style LCD bus. It rebuilds each
//   byte from its two nibble strobes, reports the completed word, and
//   raises sticky flags for timing and protocol violations.
//
// Ports:
//   clk           system clock; all logic runs on its rising edge
//   reset         asynchronous, active-low reset
//   LCD_E         enable strobe, synchronous to clk
//   LCD_RS        register select
//   LCD_RW        read/write (0 = write)
//   SF_D[3:0]     data nibble
//   clr_err       synchronous clear of both sticky error flags
//   db_out[9:0]   last received word {RS, RW, byte[7:0]}
//   db_valid      one-cycle pulse when db_out updates
//   low_phase     1 while the high nibble is held and the low nibble is awaited
//   err_timing    sticky timing-violation flag
//   err_protocol  sticky protocol-violation flag
//   word_count    received-word count, wraps 255 -> 0
// ----------------------------------------------------------------------------
module lcd_nibble_receiver #(
    parameter int E_MIN_HIGH   = 12,
    parameter int NIB_GAP_MIN  = 50,
    parameter int BYTE_GAP_MIN = 2000,
    parameter int NIB_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [3:0] SF_D,
    input  logic       clr_err,
    output logic [9:0] db_out,
    output logic       db_valid,
    output logic       low_phase,
    output logic       err_timing,
    output logic       err_protocol,
    output logic [7:0] word_count
);

    localparam logic [12:0] CNT_MAX      = 13'h1FFF;
    localparam logic [12:0] E_MIN_C      = 13'(E_MIN_HIGH);
    localparam logic [12:0] NIB_GAP_C    = 13'(NIB_GAP_MIN);
    localparam logic [12:0] BYTE_GAP_C   = 13'(BYTE_GAP_MIN);
    localparam logic [12:0] NIB_TMO_C    = 13'(NIB_TIMEOUT);

    typedef enum logic {
        ST_HI = 1'b0,
        ST_LO = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        e_q;
    logic [3:0]  cap_nib_q, cap_nib_d;
    logic        cap_rs_q, cap_rs_d;
    logic        cap_rw_q, cap_rw_d;
    logic [3:0]  hi_nib_q, hi_nib_d;
    logic        hi_rs_q, hi_rs_d;
    logic        hi_rw_q, hi_rw_d;
    logic [12:0] high_cnt_q, high_cnt_d;
    logic [12:0] gap_cnt_q, gap_cnt_d;
    logic        first_q, first_d;
    logic [9:0]  db_out_q, db_out_d;
    logic        db_valid_q, db_valid_d;
    logic        err_timing_q, err_timing_d;
    logic        err_protocol_q, err_protocol_d;
    logic [7:0]  word_count_q, word_count_d;

    logic        rise;
    logic        fall;
    logic        timing_viol;
    logic        protocol_viol;

    assign rise = LCD_E & ~e_q;
    assign fall = ~LCD_E & e_q;

    // State register and all datapath flops. Reset forces the receiver back
    // to waiting for a high nibble and re-arms the first-rise exemption.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_HI;
            e_q            <= 1'b0;
            cap_nib_q      <= 4'h0;
            cap_rs_q       <= 1'b0;
            cap_rw_q       <= 1'b0;
            hi_nib_q       <= 4'h0;
            hi_rs_q        <= 1'b0;
            hi_rw_q        <= 1'b0;
            high_cnt_q     <= 13'd0;
            gap_cnt_q      <= 13'd0;
            first_q        <= 1'b1;
            db_out_q       <= 10'd0;
            db_valid_q     <= 1'b0;
            err_timing_q   <= 1'b0;
            err_protocol_q <= 1'b0;
            word_count_q   <= 8'd0;
        end else begin
            state_q        <= state_d;
            e_q            <= LCD_E;
            cap_nib_q      <= cap_nib_d;
            cap_rs_q       <= cap_rs_d;
            cap_rw_q       <= cap_rw_d;
            hi_nib_q       <= hi_nib_d;
            hi_rs_q        <= hi_rs_d;
            hi_rw_q        <= hi_rw_d;
            high_cnt_q     <= high_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            first_q        <= first_d;
            db_out_q       <= db_out_d;
            db_valid_q     <= db_valid_d;
            err_timing_q   <= err_timing_d;
            err_protocol_q <= err_protocol_d;
            word_count_q   <= word_count_d;
        end
    end

    // Next-state and datapath logic. Bus fields are sampled on every cycle
    // E is high, so at the fall cycle the copies hold the last high-cycle
    // values. Both counters treat the edge cycle itself as the first counted
    // cycle, so a count equals the number of cycles E spent in that level.
    always_comb begin
        state_d        = state_q;
        cap_nib_d      = cap_nib_q;
        cap_rs_d       = cap_rs_q;
        cap_rw_d       = cap_rw_q;
        hi_nib_d       = hi_nib_q;
        hi_rs_d        = hi_rs_q;
        hi_rw_d        = hi_rw_q;
        high_cnt_d     = high_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        first_d        = first_q;
        db_out_d       = db_out_q;
        db_valid_d     = 1'b0;
        word_count_d   = word_count_q;
        timing_viol    = 1'b0;
        protocol_viol  = 1'b0;

        if (LCD_E) begin
            cap_nib_d = SF_D;
            cap_rs_d  = LCD_RS;
            cap_rw_d  = LCD_RW;
        end

        if (rise) begin
            high_cnt_d = 13'd1;
        end else if (LCD_E && (high_cnt_q != CNT_MAX)) begin
            high_cnt_d = high_cnt_q + 13'd1;
        end

        if (fall) begin
            gap_cnt_d = 13'd1;
        end else if (gap_cnt_q != CNT_MAX) begin
            gap_cnt_d = gap_cnt_q + 13'd1;
        end

        // Setup-gap checks at the start of each strobe. The very first strobe
        // after reset has no meaningful preceding gap and is exempt.
        if (rise) begin
            first_d = 1'b0;
            if ((state_q == ST_LO) && (gap_cnt_q < NIB_GAP_C)) begin
                timing_viol = 1'b1;
            end
            if ((state_q == ST_HI) && !first_q && (gap_cnt_q < BYTE_GAP_C)) begin
                timing_viol = 1'b1;
            end
        end

        if (fall) begin
            if (high_cnt_q < E_MIN_C) begin
                timing_viol = 1'b1;
            end
            // A read strobe on a write-only monitor is flagged, but the nibble
            // is still assembled as usual.
            if (cap_rw_q) begin
                protocol_viol = 1'b1;
            end
            if (state_q == ST_HI) begin
                hi_nib_d = cap_nib_q;
                hi_rs_d  = cap_rs_q;
                hi_rw_d  = cap_rw_q;
                state_d  = ST_LO;
            end else begin
                if ((cap_rs_q == hi_rs_q) && (cap_rw_q == hi_rw_q)) begin
                    db_out_d     = {cap_rs_q, cap_rw_q, hi_nib_q, cap_nib_q};
                    db_valid_d   = 1'b1;
                    word_count_d = word_count_q + 8'd1;
                end else begin
                    protocol_viol = 1'b1;
                end
                state_d = ST_HI;
            end
        end else if ((state_q == ST_LO) && !rise && (gap_cnt_q >= NIB_TMO_C)) begin
            // The low nibble never came: drop the half byte and resync.
            protocol_viol = 1'b1;
            state_d       = ST_HI;
        end

        // A violation in the same cycle as clr_err keeps the flag set.
        err_timing_d   = (err_timing_q & ~clr_err) | timing_viol;
        err_protocol_d = (err_protocol_q & ~clr_err) | protocol_viol;
    end

    assign db_out       = db_out_q;
    assign db_valid     = db_valid_q;
    assign low_phase    = (state_q == ST_LO);
    assign err_timing   = err_timing_q;
    assign err_protocol = err_protocol_q;
    assign word_count   = word_count_q;

endmodule
